div_sequential: RTL and testbench

DIV_SEQUENTIAL -- requirements
Module: div_sequential

---
 rtl/div_sequential.sv | 194 +++++++++++++++++++
 tb/tb_div_sequential.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequential.sv
// -----------------------------------------------------------------------------
// div_sequential
//
// Multi-cycle signed integer divider. The magnitudes of the operands are
// divided with an unsigned restoring algorithm (one quotient bit per clock,
// MSB first), then the signs are applied in a final fix-up cycle.
//
// Latency from the accepting edge to the done pulse:
//   NW + 1 cycles for a normal division, 1 cycle for a divide by zero.
//
// Quotient truncates toward zero. The remainder takes the dividend's sign and
// satisfies |r| < |b|.
//
// Configuration macro:
//   DIV_SAT_EN  defined   -> overflow (most-negative / -1) returns the
//                            saturated value 2^(NW-1)-1
//               undefined -> overflow returns the wrapped value -2^(NW-1)
//
// Parameters:
//   NW  dividend / quotient width (>= 2)
//   DW  divisor / remainder width (2..NW)
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   asynchronous reset, active high
//   start  in   1   request pulse, accepted only while busy = 0 in IDLE
//   a_in   in   NW  signed dividend, sampled on the accepting edge
//   b_in   in   DW  signed divisor, sampled on the accepting edge
//   busy   out  1   high while the iteration is running
//   done   out  1   one-cycle pulse, results valid from this cycle on
//   q_out  out  NW  signed quotient, held until the next done
//   r_out  out  DW  signed remainder, held until the next done
//   dz     out  1   divide-by-zero flag, updated with done
//   ovf    out  1   overflow flag, updated with done
// -----------------------------------------------------------------------------
module div_sequential #(
    parameter int NW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] q_out,
    output logic [DW-1:0] r_out,
    output logic          dz,
    output logic          ovf
);

    localparam int CW = $clog2(NW + 1);

    localparam logic [NW-1:0] NEG_MIN = {1'b1, {(NW-1){1'b0}}};
    localparam logic [NW-1:0] POS_MAX = {1'b0, {(NW-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t        state;

    // Dividend magnitude shifts out of the top while quotient bits shift in
    // at the bottom, so after NW steps this register holds |q|.
    logic [NW-1:0] a_sh;
    logic [DW-1:0] b_abs;
    logic [DW-1:0] rem;
    logic [CW-1:0] cnt;
    logic          sign_a;
    logic          sign_b;
    logic          dz_pend;
    logic          ovf_pend;

    // Combinational datapath
    logic [NW-1:0] a_mag;
    logic [DW-1:0] b_mag;
    logic [DW:0]   part_rem;
    logic [DW-1:0] diff;
    logic          ge;
    logic [DW-1:0] rem_next;
    logic [NW-1:0] q_signed;
    logic [DW-1:0] r_signed;

    // NOTE: every signal written in always_comb gets a value on every path
    // (here unconditionally); a missing assignment would infer a latch.
    always_comb begin
        // Two's-complement negate; the most-negative value maps onto its
        // correct unsigned magnitude 2^(W-1).
        a_mag    = a_in[NW-1] ? -a_in : a_in;
        b_mag    = b_in[DW-1] ? -b_in : b_in;

        // Partial remainder is one bit wider than the divisor, so shifting in
        // the next dividend bit cannot overflow even when |b| = 2^(DW-1).
        part_rem = {rem, a_sh[NW-1]};
        ge       = (part_rem >= {1'b0, b_abs});
        // When ge is set the true difference is below |b| and fits DW bits.
        diff     = part_rem[DW-1:0] - b_abs;
        rem_next = ge ? diff : part_rem[DW-1:0];

        q_signed = (sign_a ^ sign_b) ? -a_sh : a_sh;
        r_signed = sign_a ? -rem : rem;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            q_out    <= '0;
            r_out    <= '0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
            a_sh     <= '0;
            b_abs    <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            dz_pend  <= 1'b0;
            ovf_pend <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh     <= a_mag;
                        b_abs    <= b_mag;
                        sign_a   <= a_in[NW-1];
                        sign_b   <= b_in[DW-1];
                        rem      <= '0;
                        cnt      <= CW'(NW);
                        dz_pend  <= (b_in == '0);
                        ovf_pend <= (a_in == NEG_MIN) && (b_in == '1);
                        if (b_in == '0) begin
                            // No iteration needed; resolve in the next cycle.
                            state <= FIX;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    rem  <= rem_next;
                    a_sh <= {a_sh[NW-2:0], ge};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        // Last quotient bit lands on this edge.
                        busy  <= 1'b0;
                        state <= FIX;
                    end
                end

                FIX: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (dz_pend) begin
                        q_out <= '1;
                        r_out <= '0;
                        dz    <= 1'b1;
                        ovf   <= 1'b0;
                    end else if (ovf_pend) begin
`ifdef DIV_SAT_EN
                        q_out <= POS_MAX;
`else
                        q_out <= NEG_MIN;
`endif
                        r_out <= '0;
                        dz    <= 1'b0;
                        ovf   <= 1'b1;
                    end else begin
                        q_out <= q_signed;
                        r_out <= r_signed;
                        dz    <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequential.sv
// -----------------------------------------------------------------------------
// tb_div_sequential
//
// Directed testbench for div_sequential with NW = DW = 32. Inputs are driven
// on the falling edge; outputs are sampled on the falling edge as well, half a
// cycle away from the rising edge where the DUT updates.
// -----------------------------------------------------------------------------
module tb_div_sequential;

    localparam int NW = 32;
    localparam int DW = 32;
    localparam int MAX_WAIT = 100;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          busy;
    logic          done;
    logic [NW-1:0] q_out;
    logic [DW-1:0] r_out;
    logic          dz;
    logic          ovf;

    int total;
    int bad;

    div_sequential #(.NW(NW), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .q_out (q_out),
        .r_out (r_out),
        .dz    (dz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (on falling edges) until done is seen, counting cycles since the
    // accepting edge and cycles with busy high. Called at the falling edge
    // right after the accepting edge.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < MAX_WAIT) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (lat >= MAX_WAIT) begin
            bad++;
            $display("FAIL wait_done: done not seen within %0d cycles", MAX_WAIT);
        end
        total++;
    endtask

    // Issues one start pulse and waits for its done.
    task automatic run_op(input logic [NW-1:0] a, input logic [DW-1:0] b,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_cyc);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        if ({busy, done, dz, ovf} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got busy/done/dz/ovf=%b want 0000",
                     {busy, done, dz, ovf});
        end
        total++;
        if (q_out !== 32'd0 || r_out !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: got q=%h r=%h want 0 0", q_out, r_out);
        end
        total++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bcyc;
        run_op(32'd100, 32'd7, lat, bcyc);
        if (lat !== 33) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 33", lat);
        end
        total++;
        if (bcyc !== 32) begin
            bad++;
            $display("FAIL basic_busy_cycles: got %0d want 32", bcyc);
        end
        total++;
        if (q_out !== 32'd14 || r_out !== 32'd2 || dz !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b ovf=%b want 14 2 0 0",
                     $signed(q_out), $signed(r_out), dz, ovf);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_on_done: got %b want 0", busy);
        end
        total++;
        @(negedge clk);
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse: got done=%b after pulse want 0", done);
        end
        total++;
        if (q_out !== 32'd14 || r_out !== 32'd2) begin
            bad++;
            $display("FAIL basic_hold: got q=%0d r=%0d want 14 2",
                     $signed(q_out), $signed(r_out));
        end
        total++;
    endtask

    task automatic test_signs();
        logic [31:0] va [6] = '{-32'sd100, 32'sd100, -32'sd100, 32'sd7,
                                -32'sd1, 32'sd2147483647};
        logic [31:0] vb [6] = '{32'sd7, -32'sd7, -32'sd7, 32'sd100,
                                32'sh8000_0000, 32'sd2};
        logic [31:0] vq [6] = '{-32'sd14, -32'sd14, 32'sd14, 32'sd0,
                                32'sd0, 32'sd1073741823};
        logic [31:0] vr [6] = '{-32'sd2, 32'sd2, -32'sd2, 32'sd7,
                                -32'sd1, 32'sd1};
        int lat, bcyc;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], lat, bcyc);
            if (q_out !== vq[i] || r_out !== vr[i] || dz !== 1'b0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL signs[%0d]: %0d/%0d got q=%0d r=%0d dz=%b ovf=%b want q=%0d r=%0d",
                         i, $signed(va[i]), $signed(vb[i]), $signed(q_out),
                         $signed(r_out), dz, ovf, $signed(vq[i]), $signed(vr[i]));
            end
            total++;
        end
    endtask

    task automatic test_div_zero();
        int lat, bcyc;
        run_op(32'd5, 32'd0, lat, bcyc);
        if (lat !== 1) begin
            bad++;
            $display("FAIL dz_latency: got %0d want 1", lat);
        end
        total++;
        if (q_out !== 32'hFFFF_FFFF || r_out !== 32'd0 || dz !== 1'b1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL dz_result: got q=%h r=%h dz=%b ovf=%b want ffffffff 0 1 0",
                     q_out, r_out, dz, ovf);
        end
        total++;
    endtask

    task automatic test_overflow();
        int lat, bcyc;
        logic [31:0] q_exp;
`ifdef DIV_SAT_EN
        q_exp = 32'h7FFF_FFFF;
`else
        q_exp = 32'h8000_0000;
`endif
        run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
        if (q_out !== q_exp || r_out !== 32'd0 || ovf !== 1'b1 || dz !== 1'b0) begin
            bad++;
            $display("FAIL ovf_result: got q=%h r=%h ovf=%b dz=%b want %h 0 1 0",
                     q_out, r_out, ovf, dz, q_exp);
        end
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL ovf_latency: got %0d want 33", lat);
        end
        total++;
    endtask

    // Start while busy is ignored; start on the done cycle is accepted.
    task automatic test_back_to_back();
        int lat, bcyc;
        @(negedge clk);
        start = 1'b1;
        a_in  = 32'd100;
        b_in  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
            start = (lat == 9);
            if (lat == 9) begin
                a_in = 32'd9;
                b_in = 32'd3;
            end
        end
        start = 1'b0;
        if (lat !== 33 || q_out !== 32'd14 || r_out !== 32'd2) begin
            bad++;
            $display("FAIL ignore_busy_start: got lat=%0d q=%0d r=%0d want 33 14 2",
                     lat, $signed(q_out), $signed(r_out));
        end
        total++;
        // done is high now; request the next operation in this same cycle.
        start = 1'b1;
        a_in  = 32'd9;
        b_in  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL done_cycle_accept: got busy=%b want 1", busy);
        end
        total++;
        wait_done(lat, bcyc);
        if (lat !== 33 || q_out !== 32'd3 || r_out !== 32'd0) begin
            bad++;
            $display("FAIL back_to_back_result: got lat=%0d q=%0d r=%0d want 33 3 0",
                     lat, $signed(q_out), $signed(r_out));
        end
        total++;
    endtask

    task automatic test_reset_midflight();
        int lat, bcyc;
        int seen;
        @(negedge clk);
        start = 1'b1;
        a_in  = 32'd100;
        b_in  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        if ({busy, done, dz, ovf} !== 4'b0000 || q_out !== 32'd0 || r_out !== 32'd0) begin
            bad++;
            $display("FAIL midflight_reset: got busy=%b done=%b dz=%b ovf=%b q=%h r=%h want all 0",
                     busy, done, dz, ovf, q_out, r_out);
        end
        total++;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        if (seen !== 0) begin
            bad++;
            $display("FAIL abandoned_op: got %0d cycles with done/busy want 0", seen);
        end
        total++;
        run_op(-32'sd100, 32'd7, lat, bcyc);
        if (lat !== 33 || q_out !== -32'sd14 || r_out !== -32'sd2) begin
            bad++;
            $display("FAIL after_reset_op: got lat=%0d q=%0d r=%0d want 33 -14 -2",
                     lat, $signed(q_out), $signed(r_out));
        end
        total++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
